noc_qsys_nios2_00_cpu_debug_mem_seq: RTL and testbench
======================================================

// Module: noc_qsys_nios2_00_cpu_debug_mem_seq
// PURPOSE
//  Consumes the sysclk-domain debug commands (jdo, take_action_ocimem_*) from the debug slave
//  wrapper and sequences single-word read/write accesses to the on-chip debug/monitor RAM.
//  Returns read data and status (MonDReg, monitor_ready) for the JTAG TCK side to shift out.
//  Holds a post-incrementing address register so consecutive JTAG scans stream through memory.
// PARAMETERS
//  ADDR_W   8   word-address width; address field jdo[25+ADDR_W:26]; legal 1..9
//  RD_LAT   1   RAM read latency in clk cycles after grant; legal 1..3
// PORTS
//  clk                      in   1       system clock
//  reset_n                  in   1       synchronous reset, active low
//  jdo                      in   38      debug command/data word, valid with take_* strobes
//  take_action_ocimem_a     in   1       load address from jdo; read if jdo[35]=1
//  take_no_action_ocimem_a  in   1       read at current address
//  take_action_ocimem_b     in   1       write jdo[34:3] at current address
//  mem_req                  out  1       RAM access request, held until granted
//  mem_we                   out  1       1=write, 0=read; valid while mem_req=1
//  mem_addr                 out  ADDR_W  RAM word address (equals MonAReg)
//  mem_wdata                out  32      RAM write data
//  mem_gnt                  in   1       RAM grant; access occurs in cycle mem_req&mem_gnt
//  mem_rdata                in   32      RAM read data, valid RD_LAT cycles after grant cycle
//  MonDReg                  out  32      last read data
//  MonAReg                  out  ADDR_W  current address
//  monitor_ready            out  1       1 = idle, last operation complete
//  mon_overrun              out  1       sticky: a command was dropped
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge): state IDLE; MonDReg, MonAReg, mem_wdata, mem_req, mem_we,
//    monitor_ready, mon_overrun all 0; latency counter 0. monitor_ready rises 1 cycle after release.
//  - Reset during REQ/WAIT aborts: no further RAM access issued; the in-flight read is discarded.
//  - FSM states: IDLE, REQ, WAIT. monitor_ready is registered (next_state==IDLE).
//  - IDLE, strobe priority a > no_action_a > b; lower-priority simultaneous strobes are dropped
//    and mon_overrun<=1.
//    * take_action_ocimem_a: MonAReg<=jdo[25+ADDR_W:26]; mon_overrun<=0;
//      jdo[35]=1 -> REQ(read), else stay IDLE.
//    * take_no_action_ocimem_a: -> REQ(read) at MonAReg.
//    * take_action_ocimem_b: mem_wdata<=jdo[34:3]; -> REQ(write).
//  - REQ: mem_req=1, mem_we per op, mem_addr=MonAReg. Hold until mem_gnt=1 is sampled (no timeout).
//    * Write granted at cycle T: at the T edge -> IDLE, mem_req<=0, MonAReg<=MonAReg+1.
//      monitor_ready=1 in T+1.
//    * Read granted at cycle T: -> WAIT, cnt<=RD_LAT, mem_req<=0.
//  - WAIT: cnt decrements each cycle. At cnt==1 (cycle T+RD_LAT): MonDReg<=mem_rdata,
//    MonAReg<=MonAReg+1, -> IDLE. monitor_ready=1 in T+RD_LAT+1.
//  - Address increment wraps 2^ADDR_W-1 -> 0.
//  - Any strobe in REQ/WAIT: ignored, mon_overrun<=1; the in-flight operation is unaffected.
//  - mem_req never asserts in IDLE or WAIT; at most one access is outstanding.
//  - MonDReg changes only on read completion or reset.
// TESTING
//  1. Reset, then take_action_ocimem_a with jdo[33:26]=8'h10, jdo[35]=1; mem_gnt tied 1,
//     RAM[16]=32'hCAFE0001 -> mem_req 1 cycle at addr 16; MonDReg=CAFE0001 at T+2;
//     MonAReg=8'h11; monitor_ready=1.
//  2. Write: take_action_ocimem_b, jdo[34:3]=32'h12345678, MonAReg=8'hFF; mem_gnt delayed
//     3 cycles -> mem_req held 3 cycles, mem_we=1; RAM[255] written once; MonAReg wraps to 0.
//  3. RD_LAT=3: read, grant at T -> MonDReg updates exactly at T+3 edge; monitor_ready=0 from
//     strobe through T+3, 1 at T+4.
//  4. Two take_no_action_ocimem_a strobes 1 cycle apart -> only one read issued;
//     mon_overrun=1; next accepted take_action_ocimem_a clears it.
//  5. take_action_ocimem_a and take_action_ocimem_b in the same cycle -> address load only,
//     no write; mon_overrun stays 0 (cleared by a), then is set by the dropped b.
//     Required net result: mon_overrun=1.
//  6. reset_n=0 for 1 cycle while in REQ (mem_gnt=0) -> mem_req=0 next cycle; no access
//     after mem_gnt rises; all outputs return to 0.

Source files
------------

// File: rtl/noc_qsys_nios2_00_cpu_debug_mem_seq_if.sv
// Debug/monitor RAM access bus between the debug memory sequencer and the RAM.
//   mem_req   : access request, held until granted
//   mem_we    : 1 = write, 0 = read (valid while mem_req = 1)
//   mem_addr  : RAM word address
//   mem_wdata : RAM write data
//   mem_gnt   : grant; the access takes place in the cycle where mem_req & mem_gnt
//   mem_rdata : read data, valid RD_LAT cycles after the grant cycle
interface noc_qsys_nios2_00_cpu_debug_mem_seq_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/noc_qsys_nios2_00_cpu_debug_mem_seq.sv
// Debug memory sequencer: takes sysclk-domain debug commands (jdo + take_* strobes) and
// performs single-word reads/writes to the on-chip debug/monitor RAM, with a
// post-incrementing address register so consecutive JTAG scans stream through memory.
// Ports:
//   clk, reset_n              : clock, synchronous active-low reset
//   jdo                       : command/data word, valid with the take_* strobes
//   take_action_ocimem_a      : load address from jdo, read if jdo[35]
//   take_no_action_ocimem_a   : read at current address
//   take_action_ocimem_b      : write jdo[34:3] at current address
//   mem                       : RAM bus (master side)
//   MonDReg / MonAReg         : last read data / current address
//   monitor_ready             : idle, last operation complete
//   mon_overrun               : sticky, a command was dropped
module noc_qsys_nios2_00_cpu_debug_mem_seq #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [37:0]                                  jdo,
  input  logic                                         take_action_ocimem_a,
  input  logic                                         take_no_action_ocimem_a,
  input  logic                                         take_action_ocimem_b,
  noc_qsys_nios2_00_cpu_debug_mem_seq_if.master        mem,
  output logic [31:0]                                  MonDReg,
  output logic [ADDR_W-1:0]                            MonAReg,
  output logic                                         monitor_ready,
  output logic                                         mon_overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  localparam logic [1:0] RD_LAT_V = 2'(RD_LAT);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       dreg_q, dreg_d;
  logic [ADDR_W-1:0] areg_q, areg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;
  logic              any_strobe;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dreg_d    = dreg_q;
    areg_d    = areg_q;
    wdata_d   = wdata_q;
    req_d     = req_q;
    we_d      = we_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (take_action_ocimem_a) begin
          areg_d    = jdo[25+ADDR_W:26];
          // The clear from this command loses to a simultaneously dropped strobe.
          overrun_d = take_no_action_ocimem_a | take_action_ocimem_b;
          if (jdo[35]) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = 1'b0;
          end
        end else if (take_no_action_ocimem_a) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = 1'b0;
          if (take_action_ocimem_b) overrun_d = 1'b1;
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          state_d = ST_REQ;
          req_d   = 1'b1;
          we_d    = 1'b1;
        end
      end
      ST_REQ: begin
        if (any_strobe) overrun_d = 1'b1;
        if (mem.mem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = ST_IDLE;
            areg_d  = areg_q + ADDR_W'(1);
          end else begin
            state_d = ST_WAIT;
            cnt_d   = RD_LAT_V;
          end
        end
      end
      ST_WAIT: begin
        if (any_strobe) overrun_d = 1'b1;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          dreg_d  = mem.mem_rdata;
          areg_d  = areg_q + ADDR_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dreg_q    <= '0;
      areg_q    <= '0;
      wdata_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dreg_q    <= dreg_d;
      areg_q    <= areg_d;
      wdata_q   <= wdata_d;
      req_q     <= req_d;
      we_q      <= we_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = areg_q;
  assign mem.mem_wdata = wdata_q;
  assign MonDReg       = dreg_q;
  assign MonAReg       = areg_q;
  assign monitor_ready = ready_q;
  assign mon_overrun   = overrun_q;

endmodule

// File: tb/tb_noc_qsys_nios2_00_cpu_debug_mem_seq.sv
module tb_noc_qsys_nios2_00_cpu_debug_mem_seq;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic [1:0]  ta, tn, tw, gnt;
  logic [31:0] mdr0, mdr1;
  logic [7:0]  mar0, mar1;
  logic        rdy0, rdy1, ovr0, ovr1;

  int n_checks = 0;
  int n_fail   = 0;

  acc_t q0[$];
  acc_t q1[$];

  logic [31:0] ram0 [256];
  logic [31:0] ram1 [256];
  logic [31:0] p0;
  logic [31:0] p1 [3];
  int          wr_ff0 = 0;

  always #5 clk = ~clk;

  noc_qsys_nios2_00_cpu_debug_mem_seq_if #(.ADDR_W(8)) bus0 ();
  noc_qsys_nios2_00_cpu_debug_mem_seq_if #(.ADDR_W(8)) bus1 ();

  noc_qsys_nios2_00_cpu_debug_mem_seq #(.ADDR_W(8), .RD_LAT(1)) dut0 (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta[0]),
    .take_no_action_ocimem_a (tn[0]),
    .take_action_ocimem_b    (tw[0]),
    .mem                     (bus0.master),
    .MonDReg                 (mdr0),
    .MonAReg                 (mar0),
    .monitor_ready           (rdy0),
    .mon_overrun             (ovr0)
  );

  noc_qsys_nios2_00_cpu_debug_mem_seq #(.ADDR_W(8), .RD_LAT(3)) dut1 (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta[1]),
    .take_no_action_ocimem_a (tn[1]),
    .take_action_ocimem_b    (tw[1]),
    .mem                     (bus1.master),
    .MonDReg                 (mdr1),
    .MonAReg                 (mar1),
    .monitor_ready           (rdy1),
    .mon_overrun             (ovr1)
  );

  assign bus0.mem_gnt   = gnt[0];
  assign bus1.mem_gnt   = gnt[1];
  assign bus0.mem_rdata = p0;
  assign bus1.mem_rdata = p1[2];

  // RAM models: read data appears RD_LAT cycles after the grant cycle, filler otherwise.
  always @(posedge clk) begin
    if (bus0.mem_req && bus0.mem_gnt) begin
      if (bus0.mem_we) begin
        ram0[bus0.mem_addr] <= bus0.mem_wdata;
        if (bus0.mem_addr == 8'hFF) wr_ff0 <= wr_ff0 + 1;
      end
      p0 <= bus0.mem_we ? 32'hBAD0BAD0 : ram0[bus0.mem_addr];
    end else begin
      p0 <= 32'hBAD0BAD0;
    end
  end

  always @(posedge clk) begin
    if (bus1.mem_req && bus1.mem_gnt) begin
      if (bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
      p1[0] <= bus1.mem_we ? 32'hBAD1BAD1 : ram1[bus1.mem_addr];
    end else begin
      p1[0] <= 32'hBAD1BAD1;
    end
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every granted access is matched against the queue of expected accesses.
  always @(negedge clk) begin
    acc_t obs, e;
    if (reset_n === 1'b1 && bus0.mem_req === 1'b1 && bus0.mem_gnt === 1'b1) begin
      obs = '{we: bus0.mem_we, addr: bus0.mem_addr,
              wdata: bus0.mem_we ? bus0.mem_wdata : 32'h0};
      if (q0.size() == 0) check("acc0_spurious", 64'(obs), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q0.pop_front();
        check("acc0", 64'(obs), 64'(e));
      end
    end
    if (reset_n === 1'b1 && bus1.mem_req === 1'b1 && bus1.mem_gnt === 1'b1) begin
      obs = '{we: bus1.mem_we, addr: bus1.mem_addr,
              wdata: bus1.mem_we ? bus1.mem_wdata : 32'h0};
      if (q1.size() == 0) check("acc1_spurious", 64'(obs), 64'hFFFF_FFFF_FFFF_FFFF);
      else begin
        e = q1.pop_front();
        check("acc1", 64'(obs), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] addr);
    logic [37:0] d;
    d        = '0;
    d[35]    = rd;
    d[33:26] = addr;
    return d;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] wd);
    logic [37:0] d;
    d       = '0;
    d[34:3] = wd;
    return d;
  endfunction

  task automatic strobe(input int s, input logic a, input logic n, input logic b,
                        input logic [37:0] d);
    jdo   = d;
    ta[s] = a;
    tn[s] = n;
    tw[s] = b;
    tick();
    ta  = '0;
    tn  = '0;
    tw  = '0;
    jdo = '0;
  endtask

  task automatic wait_ready(input int s);
    int n;
    n = 0;
    while (!(s == 0 ? rdy0 : rdy1) && n < 50) begin
      tick();
      n++;
    end
    check("ready_timeout", 64'(s == 0 ? rdy0 : rdy1), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    jdo     = '0;
    ta      = '0;
    tn      = '0;
    tw      = '0;
    gnt     = '0;
    ram0[8'h10] <= 32'hCAFE0001;
    ram0[8'h00] <= 32'h0000A5A5;
    ram1[8'h40] <= 32'h5EED0003;
    tick();
    tick();

    // reset state
    check("rst_mdr",   64'(mdr0), 64'h0);
    check("rst_mar",   64'(mar0), 64'h0);
    check("rst_rdy",   64'(rdy0), 64'h0);
    check("rst_ovr",   64'(ovr0), 64'h0);
    check("rst_req",   64'(bus0.mem_req), 64'h0);
    check("rst_we",    64'(bus0.mem_we), 64'h0);
    check("rst_wdata", 64'(bus0.mem_wdata), 64'h0);
    reset_n = 1'b1;
    tick();
    check("rdy_after_rst", 64'(rdy0), 64'h1);

    // 1: address load + read, grant tied high, RD_LAT=1
    gnt[0] = 1'b1;
    q0.push_back('{we: 1'b0, addr: 8'h10, wdata: 32'h0});
    strobe(0, 1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'h10));
    check("t1_req",     64'(bus0.mem_req), 64'h1);
    check("t1_addr",    64'(bus0.mem_addr), 64'h10);
    check("t1_rdy_low", 64'(rdy0), 64'h0);
    tick();
    check("t1_req_drop", 64'(bus0.mem_req), 64'h0);
    check("t1_mdr_early", 64'(mdr0), 64'h0);
    tick();
    check("t1_mdr", 64'(mdr0), 64'hCAFE0001);
    check("t1_mar", 64'(mar0), 64'h11);
    check("t1_rdy", 64'(rdy0), 64'h1);

    // 3: RD_LAT=3 read on the second instance
    q1.push_back('{we: 1'b0, addr: 8'h40, wdata: 32'h0});
    strobe(1, 1'b1, 1'b0, 1'b0, mk_a(1'b1, 8'h40));
    check("t3_req",     64'(bus1.mem_req), 64'h1);
    check("t3_rdy_req", 64'(rdy1), 64'h0);
    gnt[1] = 1'b1;
    tick();
    gnt[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      check("t3_mdr_wait", 64'(mdr1), 64'h0);
      check("t3_rdy_wait", 64'(rdy1), 64'h0);
      check("t3_req_wait", 64'(bus1.mem_req), 64'h0);
      tick();
    end
    check("t3_mdr", 64'(mdr1), 64'h5EED0003);
    check("t3_rdy", 64'(rdy1), 64'h1);
    check("t3_mar", 64'(mar1), 64'h41);

    // 2: write at 0xFF with grant delayed, address wraps
    gnt[0] = 1'b0;
    strobe(0, 1'b1, 1'b0, 1'b0, mk_a(1'b0, 8'hFF));
    check("t2_mar_load", 64'(mar0), 64'hFF);
    check("t2_no_read",  64'(bus0.mem_req), 64'h0);
    q0.push_back('{we: 1'b1, addr: 8'hFF, wdata: 32'h12345678});
    strobe(0, 1'b0, 1'b0, 1'b1, mk_b(32'h12345678));
    for (int k = 1; k <= 3; k++) begin
      check("t2_req_held", 64'(bus0.mem_req), 64'h1);
      check("t2_we",       64'(bus0.mem_we), 64'h1);
      if (k == 3) gnt[0] = 1'b1;
      tick();
    end
    gnt[0] = 1'b0;
    check("t2_req_drop", 64'(bus0.mem_req), 64'h0);
    check("t2_rdy",      64'(rdy0), 64'h1);
    check("t2_mar_wrap", 64'(mar0), 64'h0);
    check("t2_wr_count", 64'(wr_ff0), 64'd1);
    check("t2_ram",      64'(ram0[8'hFF]), 64'h12345678);

    // 4: back-to-back no_action strobes -> one read, overrun set, cleared by a
    gnt[0] = 1'b1;
    q0.push_back('{we: 1'b0, addr: 8'h00, wdata: 32'h0});
    strobe(0, 1'b0, 1'b1, 1'b0, '0);
    strobe(0, 1'b0, 1'b1, 1'b0, '0);
    check("t4_ovr_set", 64'(ovr0), 64'h1);
    wait_ready(0);
    check("t4_mdr", 64'(mdr0), 64'h0000A5A5);
    check("t4_mar", 64'(mar0), 64'h01);
    strobe(0, 1'b1, 1'b0, 1'b0, mk_a(1'b0, 8'h20));
    check("t4_ovr_clr", 64'(ovr0), 64'h0);
    check("t4_mar_load", 64'(mar0), 64'h20);

    // 5: a and b together -> address load only, overrun set by the dropped b
    strobe(0, 1'b1, 1'b0, 1'b1, mk_a(1'b0, 8'h30));
    check("t5_mar", 64'(mar0), 64'h30);
    check("t5_ovr", 64'(ovr0), 64'h1);
    check("t5_req", 64'(bus0.mem_req), 64'h0);
    tick();
    tick();
    check("t5_mdr_kept", 64'(mdr0), 64'h0000A5A5);

    // 6: reset while waiting for grant aborts the access
    gnt[0] = 1'b0;
    strobe(0, 1'b0, 1'b1, 1'b0, '0);
    check("t6_req", 64'(bus0.mem_req), 64'h1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_req_rst",   64'(bus0.mem_req), 64'h0);
    check("t6_mdr_rst",   64'(mdr0), 64'h0);
    check("t6_mar_rst",   64'(mar0), 64'h0);
    check("t6_ovr_rst",   64'(ovr0), 64'h0);
    check("t6_rdy_rst",   64'(rdy0), 64'h0);
    check("t6_we_rst",    64'(bus0.mem_we), 64'h0);
    check("t6_wdata_rst", 64'(bus0.mem_wdata), 64'h0);
    gnt[0] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("t6_rdy_after", 64'(rdy0), 64'h1);
    check("t6_no_access", 64'(bus0.mem_req), 64'h0);

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
